mdu_issue_ctrl: RTL
===================

// Module: mdu_issue_ctrl
// PURPOSE
//   E-stage initiator for the multiply/divide unit. Turns the E-stage MDU op into the start/op
//   pulse the MDU consumes, mirrors the MDU's fixed latency with a local counter, and stalls
//   D-stage MDU instructions (mult/div/mt/mf) while an operation is pending.
//   Also checks the MDU's busy line against the mirrored expectation and counts stall cycles.
// PARAMETERS
//   MULT_LAT  5   cycles busy is high after the start edge for mult/multu
//   DIV_LAT   10  cycles busy is high after the start edge for div/divu
//   CNT_W     32  width of the stall-cycle counter
// PORTS
//   clk        in   1      clock
//   reset      in   1      synchronous, active-high
//   req        in   1      exception/interrupt request; MDU is frozen this cycle
//   e_valid    in   1      E-stage holds a valid instruction (one cycle per instruction)
//   e_mdu_op   in   3      E-stage op: 0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 reserved
//   d_is_mdu   in   1      D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
//   mdu_busy   in   1      busy from MDU
//   mdu_start  out  1      start pulse to MDU
//   mdu_op     out  3      op to MDU (same encoding as e_mdu_op)
//   stall_d    out  1      freeze D, insert bubble into E
//   proto_err  out  1      sticky: mdu_busy disagreed with mirrored state
//   stall_cnt  out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//   - Reset: state IDLE, exp_cnt 0, proto_err 0, stall_cnt 0; during reset, mdu_start, mdu_op
//     and stall_d are all 0. Reset mid-operation returns to IDLE immediately.
//   - mdu_op = (e_valid & ~req) ? e_mdu_op : 0. Code 7 maps to 0. mthi/mtlo pass through.
//     They produce no start and do not change state.
//   - mdu_start = e_valid & ~req & state==IDLE & e_mdu_op in {1..4}. Combinational, one cycle.
//   - If a start-type op reaches E while state==BUSY, no start is issued and proto_err is set.
//   - FSM IDLE->BUSY on the edge where mdu_start=1; exp_cnt <= MULT_LAT (ops 1,2) or DIV_LAT (ops 3,4).
//   - In BUSY with req=0: exp_cnt decrements. The edge that sees exp_cnt==1 goes to IDLE
//     (exp_cnt 0). In BUSY with req=1: state and exp_cnt hold.
//   - Busy window: mult busy spans cycles t+1..t+MULT_LAT relative to start cycle t; div spans
//     t+1..t+DIV_LAT. Each req cycle extends the window by one.
//   - stall_d = d_is_mdu & (mdu_start | state==BUSY | mdu_busy).
//   - stall_cnt += 1 on every edge with stall_d=1 & req=0; saturates at all-ones.
//   - Checker, every non-reset edge: if mdu_busy != (state==BUSY), proto_err <= 1.
//     proto_err clears only on reset.
//   - req together with a start-type op in E: start suppressed, op forced 0, state unchanged.
//     The instruction is flushed and later re-issued by the pipeline.
//   - Outputs depend only on current-cycle inputs and state; there is no combinational path
//     from mdu_busy to mdu_start.
// TESTING
//   1 mult in E at cycle 0, d_is_mdu=1 throughout, model MDU -> start=1 only at cycle 0;
//     stall_d=1 cycles 0..5, 0 at cycle 6; stall_cnt=6.
//   2 divu in E at cycle 0 with mflo in D -> stall_d=1 cycles 0..10, 0 at cycle 11;
//     stall_cnt=11; proto_err=0.
//   3 mult at cycle 0, req=1 cycles 2..4 -> exp_cnt holds at 4 during req; stall_d falls at
//     cycle 9; stall_cnt=6.
//   4 req=1 while e_valid & e_mdu_op=3 -> mdu_start=0, mdu_op=0, state stays IDLE; stall_d
//     driven only by mdu_busy.
//   5 mult issued, bench forces mdu_busy=0 at cycle 1 -> proto_err=1 from cycle 2, held
//     through 20 idle cycles, cleared by reset.
//   6 div issued at cycle 0, reset at cycle 4 -> cycle 5: state IDLE, stall_d=0, stall_cnt=0;
//     a new mtlo passes with no stall.

Source files
------------

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl -- E-stage initiator for the multiply/divide unit.
//   Converts the E-stage MDU op into the start/op pulse the MDU consumes, tracks
//   the MDU's fixed latency with a local down-counter, stalls D-stage MDU
//   instructions while an operation is pending, checks the MDU busy line
//   against the locally tracked state, and counts stall cycles.
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   req             exception/interrupt request (MDU frozen this cycle)
//   e_valid         E-stage holds a valid instruction
//   e_mdu_op[2:0]   E-stage op: 0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 rsvd
//   d_is_mdu        D-stage instruction uses the MDU
//   mdu_busy        busy from the MDU
//   mdu_start       start pulse to the MDU
//   mdu_op[2:0]     op to the MDU
//   stall_d         freeze D, bubble into E
//   proto_err       sticky: mdu_busy disagreed with the tracked state
//   stall_cnt       saturating stall-cycle counter
module mdu_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             e_valid,
  input  logic [2:0]       e_mdu_op,
  input  logic             d_is_mdu,
  input  logic             mdu_busy,
  output logic             mdu_start,
  output logic [2:0]       mdu_op,
  output logic             stall_d,
  output logic             proto_err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int MAXL = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_exp_cnt;
  logic             r_proto_err;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_issue;     // E op is live this cycle (valid, not flushed, not in reset)
  logic w_start_op;  // op is one of mult/multu/div/divu
  logic w_is_div;
  logic w_start;
  logic w_stall;
  logic w_busy_st;

  assign w_busy_st  = (r_state == BUSY);
  assign w_issue    = e_valid & ~req & ~reset;
  assign w_start_op = (e_mdu_op >= 3'd1) && (e_mdu_op <= 3'd4);
  assign w_is_div   = (e_mdu_op == 3'd3) || (e_mdu_op == 3'd4);
  assign w_start    = w_issue & w_start_op & ~w_busy_st;
  // Reserved code 7 is squashed so the MDU never sees it.
  assign mdu_op     = (w_issue && e_mdu_op != 3'd7) ? e_mdu_op : 3'd0;
  assign mdu_start  = w_start;
  // mdu_busy is included so a D-stage op still waits if the MDU runs longer
  // than the tracked latency; it feeds only stall_d, never mdu_start.
  assign w_stall    = ~reset & d_is_mdu & (w_start | w_busy_st | mdu_busy);
  assign stall_d    = w_stall;
  assign proto_err  = r_proto_err;
  assign stall_cnt  = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_exp_cnt   <= '0;
      r_proto_err <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      // Busy line must track our own view of the MDU; a start-type op
      // arriving while busy means the pipeline failed to stall it.
      if ((mdu_busy != w_busy_st) || (w_issue & w_start_op & w_busy_st))
        r_proto_err <= 1'b1;

      if (w_stall && !req && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);

      case (r_state)
        IDLE: if (w_start) begin
          r_state   <= BUSY;
          r_exp_cnt <= w_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end
        BUSY: if (!req) begin
          // req freezes the MDU, so the window stretches by one per req cycle.
          if (r_exp_cnt == CW'(1)) begin
            r_state   <= IDLE;
            r_exp_cnt <= '0;
          end else begin
            r_exp_cnt <= r_exp_cnt - CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
